stack_pointer_unit: RTL and testbench
=====================================

// Module: stack_pointer_unit
// PURPOSE
//  Parametrised stack pointer for the RAT CPU datapath. Stack grows downward from SP_RESET_VAL.
//  Adds occupancy tracking, FULL/EMPTY flags, sticky overflow/underflow, and a saturate-or-wrap mode.
//  Also provides a one-entry shadow register for interrupt save/restore, and a precomputed push address.
//  Sits between the control unit (SP_* strobes) and the scratch-RAM address mux.
// PARAMETERS
//  WIDTH        8     pointer/data width in bits (2..16)
//  DEPTH        255   max stack entries; must satisfy 1 <= DEPTH <= 2**WIDTH-1
//  SP_RESET_VAL 0     SP value after reset; defines the empty stack
//  SATURATE     1     1: blocked push/pop holds SP; 0: op wraps modulo 2**WIDTH
// PORTS
//  CLK         in   1      rising-edge clock
//  RST_N       in   1      asynchronous active-low reset
//  SP_LD       in   1      load SP from DATA_IN
//  SP_INCR     in   1      pop: SP+1
//  SP_DECR     in   1      push: SP-1
//  SP_SAVE     in   1      copy current (pre-update) SP into shadow
//  SP_RESTORE  in   1      load SP from shadow
//  ERR_CLR     in   1      clear OVF/UNF
//  DATA_IN     in   WIDTH  load value
//  DATA_OUT    out  WIDTH  current SP (registered)
//  PUSH_ADDR   out  WIDTH  DATA_OUT-1 mod 2**WIDTH (combinational)
//  OCCUPANCY   out  WIDTH  (SP_RESET_VAL-DATA_OUT) mod 2**WIDTH (combinational)
//  FULL        out  1      OCCUPANCY >= DEPTH
//  EMPTY       out  1      OCCUPANCY == 0
//  OVF         out  1      sticky overflow
//  UNF         out  1      sticky underflow
// BEHAVIOUR
//  - RST_N low, async: DATA_OUT=SP_RESET_VAL, shadow=SP_RESET_VAL, OVF=0, UNF=0. Reset overrides any in-flight op.
//  - SP update priority, one op per cycle: RESTORE > LD > (INCR xor DECR). INCR&DECR together = hold, no flag.
//  - Latency: SP/flags update on the next CLK edge. PUSH_ADDR, OCCUPANCY, FULL and EMPTY follow DATA_OUT the same cycle.
//  - DECR while FULL is an overflow. Sets OVF.
//    SATURATE=1: SP holds. SATURATE=0: SP decrements and wraps.
//  - INCR while EMPTY is an underflow. Sets UNF.
//    SATURATE=1: SP holds. SATURATE=0: SP increments and wraps.
//  - DECR/INCR with no boundary condition: plain modulo +-1, no flag.
//  - LD or RESTORE always accepted. If the resulting occupancy > DEPTH, OVF sets on the same edge.
//  - SP_SAVE is independent of the priority chain.
//    Captures DATA_OUT as it was before the edge, even when an op is active in the same cycle.
//    SAVE+RESTORE together: SP <= old shadow; shadow <= old SP (swap).
//  - ERR_CLR clears OVF/UNF. A new error in the same cycle wins, so the flag stays 1.
//  - A strobe ignored by priority has no side effect and sets no flag.
// STRUCTURE
//  - Shared package sp_pkg:
//    typedef enum logic [2:0] sp_op_e {SP_OP_HOLD, SP_OP_RESTORE, SP_OP_LD, SP_OP_INCR, SP_OP_DECR}
//    function sp_occupancy(sp, reset_val, width)
//  - Sub-module sp_op_decode: pure combinational priority encoder.
//    Maps strobes + FULL/EMPTY + SATURATE to sp_op_e plus ovf_set/unf_set.
//  - Top level holds the SP register, shadow register and sticky flags, plus combinational outputs.
// TESTING (WIDTH=8, DEPTH=4, SP_RESET_VAL=0 unless noted)
//  1 Reset mid-operation: assert RST_N=0 async while SP=0xFD, DECR active.
//    -> DATA_OUT=0x00, EMPTY=1, flags 0, no wait for CLK.
//  2 Four DECR pulses -> SP FF,FE,FD,FC; PUSH_ADDR=FB; FULL=1.
//    5th DECR with SATURATE=1 -> SP stays FC, OVF=1.
//    Same with SATURATE=0 -> SP=FB, OVF=1.
//  3 INCR from reset -> SATURATE=1: SP=00, UNF=1. SATURATE=0: SP=01, UNF=1.
//    ERR_CLR+INCR same cycle -> UNF stays 1.
//  4 Priority: SP=FE, assert RESTORE(shadow=00)+LD(DATA_IN=0x80)+DECR -> SP=00.
//    Then LD 0x80 -> SP=80, OCCUPANCY=0x80, OVF=1.
//  5 Interrupt path: SP=FD, SAVE+DECR same cycle -> shadow=FD, SP=FC.
//    Later RESTORE -> SP=FD. SAVE+RESTORE with shadow=10, SP=20 -> SP=10, shadow=20.
//  6 INCR+DECR together at SP=FE -> SP stays FE, no flags. Randomised ops vs reference model, 10k cycles.

Source files
------------

// File: rtl/sp_pkg.sv
// Shared types and helpers for the RAT CPU stack pointer unit.
package sp_pkg;

  typedef enum logic [2:0] {
    SP_OP_HOLD,
    SP_OP_RESTORE,
    SP_OP_LD,
    SP_OP_INCR,
    SP_OP_DECR
  } sp_op_e;

  localparam int unsigned SpMaxWidth = 16;

  // Entries in use for a downward-growing stack, modulo 2**width.
  function automatic logic [SpMaxWidth-1:0] sp_occupancy(
    input logic [SpMaxWidth-1:0] sp,
    input logic [SpMaxWidth-1:0] reset_val,
    input int unsigned           width
  );
    logic [SpMaxWidth-1:0] mask;
    mask = 16'hFFFF >> (SpMaxWidth - width);
    return (reset_val - sp) & mask;
  endfunction

endpackage

// File: rtl/sp_op_decode.sv
// Priority encoder from control-unit strobes to a single stack pointer operation plus error sets.
module sp_op_decode
  import sp_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input  logic   sp_ld_i,
  input  logic   sp_incr_i,
  input  logic   sp_decr_i,
  input  logic   sp_restore_i,
  input  logic   full_i,
  input  logic   empty_i,
  input  logic   ld_over_i,
  input  logic   restore_over_i,
  output sp_op_e op_o,
  output logic   ovf_set_o,
  output logic   unf_set_o
);

  always_comb begin
    op_o      = SP_OP_HOLD;
    ovf_set_o = 1'b0;
    unf_set_o = 1'b0;
    if (sp_restore_i) begin
      op_o      = SP_OP_RESTORE;
      ovf_set_o = restore_over_i;
    end else if (sp_ld_i) begin
      op_o      = SP_OP_LD;
      ovf_set_o = ld_over_i;
    end else if (sp_decr_i && !sp_incr_i) begin
      if (full_i) begin
        ovf_set_o = 1'b1;
        op_o      = SATURATE ? SP_OP_HOLD : SP_OP_DECR;
      end else begin
        op_o = SP_OP_DECR;
      end
    end else if (sp_incr_i && !sp_decr_i) begin
      if (empty_i) begin
        unf_set_o = 1'b1;
        op_o      = SATURATE ? SP_OP_HOLD : SP_OP_INCR;
      end else begin
        op_o = SP_OP_INCR;
      end
    end
  end

endmodule

// File: rtl/stack_pointer_unit.sv
// Downward-growing stack pointer with occupancy flags, sticky errors and an interrupt shadow.
module stack_pointer_unit
  import sp_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 255,
  parameter int unsigned SP_RESET_VAL = 0,
  parameter bit          SATURATE     = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sp_ld_i,
  input  logic             sp_incr_i,
  input  logic             sp_decr_i,
  input  logic             sp_save_i,
  input  logic             sp_restore_i,
  input  logic             err_clr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] push_addr_o,
  output logic [WIDTH-1:0] occupancy_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam logic [WIDTH-1:0] ResetVal = WIDTH'(SP_RESET_VAL);
  localparam logic [WIDTH-1:0] DepthVal = WIDTH'(DEPTH);

  function automatic logic [WIDTH-1:0] occ_of(input logic [WIDTH-1:0] sp);
    logic [SpMaxWidth-1:0] occ;
    occ = sp_occupancy(SpMaxWidth'(sp), SpMaxWidth'(ResetVal), WIDTH);
    return occ[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] sp_q, sp_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  sp_op_e op;
  logic   ovf_set, unf_set;
  logic   ld_over, restore_over;

  assign occupancy_o  = occ_of(sp_q);
  assign full_o       = occupancy_o >= DepthVal;
  assign empty_o      = occupancy_o == '0;
  assign push_addr_o  = sp_q - 1'b1;
  assign data_o       = sp_q;
  assign ovf_o        = ovf_q;
  assign unf_o        = unf_q;

  // Absolute loads are always taken; they only flag when they land past the configured depth.
  assign ld_over      = occ_of(data_i) > DepthVal;
  assign restore_over = occ_of(shadow_q) > DepthVal;

  sp_op_decode #(
    .SATURATE(SATURATE)
  ) u_decode (
    .sp_ld_i       (sp_ld_i),
    .sp_incr_i     (sp_incr_i),
    .sp_decr_i     (sp_decr_i),
    .sp_restore_i  (sp_restore_i),
    .full_i        (full_o),
    .empty_i       (empty_o),
    .ld_over_i     (ld_over),
    .restore_over_i(restore_over),
    .op_o          (op),
    .ovf_set_o     (ovf_set),
    .unf_set_o     (unf_set)
  );

  always_comb begin
    sp_d = sp_q;
    unique case (op)
      SP_OP_HOLD:    sp_d = sp_q;
      SP_OP_RESTORE: sp_d = shadow_q;
      SP_OP_LD:      sp_d = data_i;
      SP_OP_INCR:    sp_d = sp_q + 1'b1;
      SP_OP_DECR:    sp_d = sp_q - 1'b1;
      default:       sp_d = sp_q;
    endcase
  end

  // Save samples the pre-edge SP, so save+restore swaps the two registers.
  assign shadow_d = sp_save_i ? sp_q : shadow_q;
  assign ovf_d    = ovf_set | (ovf_q & ~err_clr_i);
  assign unf_d    = unf_set | (unf_q & ~err_clr_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q     <= ResetVal;
      shadow_q <= ResetVal;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      sp_q     <= sp_d;
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Checks a saturating (index 0) and a wrapping (index 1) stack pointer against a reference model.
module tb_stack_pointer_unit;

  localparam int Depth = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sp_ld = 1'b0, sp_incr = 1'b0, sp_decr = 1'b0;
  logic       sp_save = 1'b0, sp_restore = 1'b0, err_clr = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] dout [2];
  logic [7:0] push [2];
  logic [7:0] occ  [2];
  logic       full [2];
  logic       empty[2];
  logic       ovf  [2];
  logic       unf  [2];

  int checks = 0;
  int errors = 0;

  // Reference model state: SP value, shadow, sticky flags.
  int m_sp [2];
  int m_sh [2];
  bit m_ovf[2];
  bit m_unf[2];

  always #5 clk = ~clk;

  stack_pointer_unit #(
    .WIDTH(8), .DEPTH(Depth), .SP_RESET_VAL(0), .SATURATE(1'b1)
  ) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .sp_ld_i(sp_ld), .sp_incr_i(sp_incr), .sp_decr_i(sp_decr),
    .sp_save_i(sp_save), .sp_restore_i(sp_restore), .err_clr_i(err_clr), .data_i(din),
    .data_o(dout[0]), .push_addr_o(push[0]), .occupancy_o(occ[0]), .full_o(full[0]),
    .empty_o(empty[0]), .ovf_o(ovf[0]), .unf_o(unf[0])
  );

  stack_pointer_unit #(
    .WIDTH(8), .DEPTH(Depth), .SP_RESET_VAL(0), .SATURATE(1'b0)
  ) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .sp_ld_i(sp_ld), .sp_incr_i(sp_incr), .sp_decr_i(sp_decr),
    .sp_save_i(sp_save), .sp_restore_i(sp_restore), .err_clr_i(err_clr), .data_i(din),
    .data_o(dout[1]), .push_addr_o(push[1]), .occupancy_o(occ[1]), .full_o(full[1]),
    .empty_o(empty[1]), .ovf_o(ovf[1]), .unf_o(unf[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int occ_model(input int sp);
    return (256 - sp) % 256;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sp[k] = 0; m_sh[k] = 0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
    end
  endtask

  task automatic model_step(input bit ld, incr, decr, save, restore, clr, input int d);
    for (int k = 0; k < 2; k++) begin
      int  nsp = m_sp[k];
      bit  o = 1'b0;
      bit  u = 1'b0;
      bit  wrap = (k == 1);
      if (restore) begin
        nsp = m_sh[k];
        o = occ_model(nsp) > Depth;
      end else if (ld) begin
        nsp = d;
        o = occ_model(nsp) > Depth;
      end else if (decr && !incr) begin
        if (occ_model(m_sp[k]) >= Depth) o = 1'b1;
        if (!o || wrap) nsp = (m_sp[k] + 255) % 256;
      end else if (incr && !decr) begin
        if (occ_model(m_sp[k]) == 0) u = 1'b1;
        if (!u || wrap) nsp = (m_sp[k] + 1) % 256;
      end
      if (save) m_sh[k] = m_sp[k];
      m_sp[k]  = nsp;
      m_ovf[k] = o || (m_ovf[k] && !clr);
      m_unf[k] = u || (m_unf[k] && !clr);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      string t = $sformatf("%s[%0d]", tag, k);
      chk({t, "_sp"},    32'(dout[k]),  32'(m_sp[k]));
      chk({t, "_push"},  32'(push[k]),  32'((m_sp[k] + 255) % 256));
      chk({t, "_occ"},   32'(occ[k]),   32'(occ_model(m_sp[k])));
      chk({t, "_full"},  32'(full[k]),  32'(occ_model(m_sp[k]) >= Depth));
      chk({t, "_empty"}, 32'(empty[k]), 32'(occ_model(m_sp[k]) == 0));
      chk({t, "_ovf"},   32'(ovf[k]),   32'(m_ovf[k]));
      chk({t, "_unf"},   32'(unf[k]),   32'(m_unf[k]));
    end
  endtask

  task automatic clear_inputs();
    sp_ld = 0; sp_incr = 0; sp_decr = 0; sp_save = 0; sp_restore = 0; err_clr = 0;
  endtask

  task automatic cycle(input string tag, input bit ld, incr, decr, save, restore, clr,
                       input logic [7:0] d);
    sp_ld = ld; sp_incr = incr; sp_decr = decr; sp_save = save; sp_restore = restore;
    err_clr = clr; din = d;
    @(posedge clk);
    model_step(ld, incr, decr, save, restore, clr, int'(d));
    #1;
    clear_inputs();
    check_all(tag);
  endtask

  // Reset asserted between clock edges while whatever strobes are driven stay applied.
  task automatic reset_mid(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    check_all("por");

    // Reset mid-operation with SP=FD and DECR pending
    cycle("t1_ld", 1, 0, 0, 0, 0, 0, 8'hFD);
    sp_decr = 1'b1;
    reset_mid("t1_rst");
    chk("t1_sp_const", 32'(dout[0]), 32'h00);
    chk("t1_empty_const", 32'(empty[0]), 32'h1);

    // Four pushes fill a depth-4 stack, fifth overflows
    for (int i = 0; i < 4; i++) cycle("t2_push", 0, 0, 1, 0, 0, 0, 8'h00);
    chk("t2_sp_const", 32'(dout[0]), 32'hFC);
    chk("t2_push_const", 32'(push[0]), 32'hFB);
    chk("t2_full_const", 32'(full[0]), 32'h1);
    cycle("t2_ovf", 0, 0, 1, 0, 0, 0, 8'h00);
    chk("t2_sat_sp", 32'(dout[0]), 32'hFC);
    chk("t2_wrap_sp", 32'(dout[1]), 32'hFB);
    chk("t2_sat_ovf", 32'(ovf[0]), 32'h1);
    chk("t2_wrap_ovf", 32'(ovf[1]), 32'h1);

    // Underflow from empty, then clear collides with a fresh underflow
    reset_mid("t3_rst");
    cycle("t3_unf", 0, 1, 0, 0, 0, 0, 8'h00);
    chk("t3_sat_sp", 32'(dout[0]), 32'h00);
    chk("t3_wrap_sp", 32'(dout[1]), 32'h01);
    chk("t3_wrap_unf", 32'(unf[1]), 32'h1);
    cycle("t3_clr", 0, 1, 0, 0, 1, 1, 8'h00);
    cycle("t3_clr2", 0, 1, 0, 0, 0, 1, 8'h00);
    chk("t3_sat_unf_kept", 32'(unf[0]), 32'h1);

    // Priority: restore beats load beats decrement
    reset_mid("t4_rst");
    cycle("t4_d1", 0, 0, 1, 0, 0, 0, 8'h00);
    cycle("t4_d2", 0, 0, 1, 0, 0, 0, 8'h00);
    cycle("t4_prio", 1, 0, 1, 0, 1, 0, 8'h80);
    chk("t4_prio_sp", 32'(dout[0]), 32'h00);
    cycle("t4_ld", 1, 0, 0, 0, 0, 0, 8'h80);
    chk("t4_ld_sp", 32'(dout[0]), 32'h80);
    chk("t4_ld_occ", 32'(occ[0]), 32'h80);
    chk("t4_ld_ovf", 32'(ovf[0]), 32'h1);

    // Interrupt save/restore and swap
    reset_mid("t5_rst");
    cycle("t5_ld", 1, 0, 0, 0, 0, 0, 8'hFD);
    cycle("t5_save", 0, 0, 1, 1, 0, 0, 8'h00);
    chk("t5_save_sp", 32'(dout[0]), 32'hFC);
    cycle("t5_ld0", 1, 0, 0, 0, 0, 0, 8'h00);
    cycle("t5_rest", 0, 0, 0, 0, 1, 0, 8'h00);
    chk("t5_rest_sp", 32'(dout[0]), 32'hFD);
    cycle("t5_ld10", 1, 0, 0, 0, 0, 0, 8'h10);
    cycle("t5_sv10", 0, 0, 0, 1, 0, 0, 8'h00);
    cycle("t5_ld20", 1, 0, 0, 0, 0, 0, 8'h20);
    cycle("t5_swap", 0, 0, 0, 1, 1, 0, 8'h00);
    chk("t5_swap_sp", 32'(dout[0]), 32'h10);
    cycle("t5_rest2", 0, 0, 0, 0, 1, 0, 8'h00);
    chk("t5_swap_shadow", 32'(dout[0]), 32'h20);

    // Simultaneous push and pop hold
    reset_mid("t6_rst");
    cycle("t6_ld", 1, 0, 0, 0, 0, 0, 8'hFE);
    cycle("t6_both", 0, 1, 1, 0, 0, 0, 8'h00);
    chk("t6_both_sp", 32'(dout[0]), 32'hFE);
    chk("t6_both_ovf", 32'(ovf[0]), 32'h0);
    chk("t6_both_unf", 32'(unf[0]), 32'h0);

    for (int n = 0; n < 10000; n++) begin
      bit         r_ld, r_incr, r_decr, r_save, r_rest, r_clr;
      logic [7:0] r_d;
      r_ld   = ($urandom_range(0, 99) < 6);
      r_rest = ($urandom_range(0, 99) < 4);
      r_save = ($urandom_range(0, 99) < 10);
      r_incr = ($urandom_range(0, 99) < 40);
      r_decr = ($urandom_range(0, 99) < 40);
      r_clr  = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 1) == 0) r_d = 8'($urandom_range(0, 15) + 248);
      else r_d = 8'($urandom_range(0, 255));
      cycle("rnd", r_ld, r_incr, r_decr, r_save, r_rest, r_clr, r_d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
